mix_sequencer: RTL and testbench
================================

# mix_sequencer

Frame sequencer for the 24-bit saturating voice mixer. On every sample tick it walks the voice slots in order, fetches one signed sample per voice, and feeds the mixer exactly N_VOICES enabled beats per frame, so the mixer's internal beat counter never drifts. It then captures the mixed result and presents it to the audio output stage over a valid/ready handshake. It sits between the voice generators and the I2S/DAC serializer.

## Interface
- N_VOICES, 10: voices per frame; must equal the mixer's beat count.
- W, 24: sample width, signed two's complement.
- TIMEOUT, 15: maximum cycles to wait for a voice sample or for mixer ready.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- i_sample_tick  in  1  one-cycle pulse at the audio sample rate; starts a frame.
- i_voice_active  in  N_VOICES  per-voice enable mask, sampled at frame start.
- o_voice_req  out  1  request sample from voice o_voice_idx.
- o_voice_idx  out  4  voice being requested or fed, 0..N_VOICES-1.
- i_voice_data  in  W  signed voice sample.
- i_voice_valid  in  1  i_voice_data valid for the current request.
- o_mix_en  out  1  clock enable to the mixer; one pulse per voice beat.
- o_mix_data  out  W  sample presented to the mixer with o_mix_en.
- i_mix_out  in  W  mixer result.
- i_mix_rdy  in  1  mixer result-valid pulse.
- o_sample  out  W  mixed frame sample.
- o_sample_valid  out  1  o_sample holds an unconsumed frame.
- i_sample_ready  in  1  downstream accepts o_sample.
- i_clr_flags  in  1  clears all sticky flags.
- o_overrun, o_drop, o_timeout  out  1 each  sticky error flags.

## Operation
- States: IDLE, REQ, FEED, COLLECT.
- IDLE: i_sample_tick latches i_voice_active into an internal mask, sets idx=0, and moves to REQ.
- REQ: If the voice is masked off, load 0 and go to FEED with no request. Otherwise hold o_voice_req=1 with o_voice_idx=idx. On i_voice_valid (same cycle allowed), capture i_voice_data and go to FEED.
- REQ timeout: after TIMEOUT cycles without i_voice_valid, load 0, set o_timeout, and go to FEED.
- FEED: pulse o_mix_en=1 for one cycle with o_mix_data=captured value. If idx==N_VOICES-1, go to COLLECT; otherwise idx++ and return to REQ.
- COLLECT: On i_mix_rdy, register i_mix_out into o_sample, set o_sample_valid, and go to IDLE. After TIMEOUT cycles without i_mix_rdy, set o_timeout and go to IDLE with the sample unchanged.
- Output handshake: o_sample_valid clears on a cycle with i_sample_ready=1. If a new frame completes while o_sample_valid=1 and i_sample_ready=0, o_sample is overwritten, o_sample_valid stays 1, and o_drop is set.
- i_sample_tick while not IDLE: the tick is ignored, o_overrun is set, and the frame in progress continues.
- The mixer always receives exactly N_VOICES enables per frame, including timed-out and masked voices.
- Sticky flags: cleared by i_clr_flags. Same-cycle set and clear: set wins.
- No arithmetic on sample data; values pass bit-exact, signed.

## Timing
- Reset values: state IDLE, idx 0, all outputs 0.
- Reset mid-frame aborts immediately. The mixer shares rst, so both restart aligned.
- Tick registered at edge 0 with all voices giving valid in the same cycle:
  - o_mix_en high in cycles 2, 4, …, 20.
  - Mixer i_mix_rdy in cycle 21.
  - o_sample_valid high from cycle 22.
  - Frame latency: 22 cycles.
- Each voice beat takes 2 cycles minimum plus voice stall cycles.
- o_voice_req holds o_voice_idx stable until valid or timeout.
- o_mix_en is never high on consecutive cycles.

## Structure
- Shared synth package holds:
  - state enum (IDLE, REQ, FEED, COLLECT)
  - N_VOICES and W constants, also used by the mixer
  - the sample typedef (signed [W-1:0])
- One natural sub-module, seq_timer: a loadable down-counter with expiry flag, used for both REQ and COLLECT timeouts.

## Test plan
- All voices active, each returning +1000 with immediate valid, mixer model summing → o_sample_valid at cycle 22 with o_sample=10000; ten o_mix_en pulses observed.
- Mask 10'b0000000101 with voices 0 and 2 supplying 0x100000 and 0x000010 → o_mix_data sequence 0x100000, 0, 0x000010, 0 ×7; o_voice_req asserted only for idx 0 and 2.
- Voice 3 never asserts valid → after 15 cycles o_mix_data=0 for idx 3, o_timeout=1, frame still completes with ten enables.
- Second tick at cycle 10 of a frame → o_overrun=1, frame completes normally, no extra o_mix_en; i_clr_flags clears o_overrun.
- i_sample_ready held 0 across two frames → second o_sample replaces the first, o_drop=1; i_sample_ready=1 then drops o_sample_valid next cycle.
- rst asserted after the 4th o_mix_en → all outputs 0 immediately; next tick produces a correct 10-beat frame.

Source files
------------

// File: rtl/mix_sequencer_pkg.sv
// Shared constants and types for the voice-mix frame sequencer and its mixer.
package mix_sequencer_pkg;
    localparam int N_VOICES = 10;
    localparam int W        = 24;
    localparam int TIMEOUT  = 15;
    localparam int IDX_W    = 4;
    localparam int TMR_W    = $clog2(TIMEOUT + 1);

    typedef logic signed [W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        FEED    = 2'd2,
        COLLECT = 2'd3
    } state_t;
endpackage

// File: rtl/mix_sequencer_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module seq_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          expired
);
    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);
endmodule

// File: rtl/mix_sequencer.sv
// Walks the voice slots once per sample tick, feeds the mixer exactly N_VOICES
// beats, and hands the mixed result downstream.
module mix_sequencer
    import mix_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_sample_tick,
    input  logic [N_VOICES-1:0] i_voice_active,
    output logic                o_voice_req,
    output logic [IDX_W-1:0]    o_voice_idx,
    input  sample_t             i_voice_data,
    input  logic                i_voice_valid,
    output logic                o_mix_en,
    output sample_t             o_mix_data,
    input  sample_t             i_mix_out,
    input  logic                i_mix_rdy,
    output sample_t             o_sample,
    output logic                o_sample_valid,
    input  logic                i_sample_ready,
    input  logic                i_clr_flags,
    output logic                o_overrun,
    output logic                o_drop,
    output logic                o_timeout,
    output state_t              fsm_state
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_VOICES - 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx;
    logic [N_VOICES-1:0] mask;
    sample_t             data_q;
    sample_t             sample_q;
    logic                sample_valid_q;
    logic                overrun_q, drop_q, timeout_q;

    logic    mask_load, idx_inc, capture, req, feed, frame_done, timeout_set;
    sample_t cap_val;
    logic    tmr_expired;

    seq_timer #(.CW(TMR_W)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .load    ((state == IDLE) || (state == FEED)),
        .load_val(TMR_LOAD),
        .en      ((state == REQ) || (state == COLLECT)),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        mask_load   = 1'b0;
        idx_inc     = 1'b0;
        capture     = 1'b0;
        cap_val     = '0;
        req         = 1'b0;
        feed        = 1'b0;
        frame_done  = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (i_sample_tick) begin
                    mask_load = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                // Masked voices still get a zero beat so the mixer's count stays aligned.
                if (!mask[idx]) begin
                    capture   = 1'b1;
                    state_nxt = FEED;
                end else begin
                    req = 1'b1;
                    if (i_voice_valid) begin
                        capture   = 1'b1;
                        cap_val   = i_voice_data;
                        state_nxt = FEED;
                    end else if (tmr_expired) begin
                        capture     = 1'b1;
                        timeout_set = 1'b1;
                        state_nxt   = FEED;
                    end
                end
            end
            FEED: begin
                feed = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = COLLECT;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = REQ;
                end
            end
            COLLECT: begin
                if (i_mix_rdy) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end else if (tmr_expired) begin
                    timeout_set = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx    <= '0;
            mask   <= '0;
            data_q <= '0;
        end else begin
            if (mask_load) begin
                mask <= i_voice_active;
                idx  <= '0;
            end else if (idx_inc) begin
                idx <= idx + 1'b1;
            end
            if (capture) data_q <= cap_val;
        end
    end

    // Output handshake: o_sample is offered while o_sample_valid is high and is
    // consumed on any clock edge where i_sample_ready is also high; a frame that
    // completes over an unconsumed one overwrites it and raises o_drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            if (frame_done) begin
                sample_q       <= i_mix_out;
                sample_valid_q <= 1'b1;
            end else if (i_sample_ready) begin
                sample_valid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_q <= 1'b0;
            drop_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            overrun_q <= (i_sample_tick && (state != IDLE)) | (overrun_q & ~i_clr_flags);
            drop_q    <= (frame_done && sample_valid_q && !i_sample_ready) | (drop_q & ~i_clr_flags);
            timeout_q <= timeout_set | (timeout_q & ~i_clr_flags);
        end
    end

    assign o_voice_req    = req;
    assign o_voice_idx    = idx;
    assign o_mix_en       = feed;
    assign o_mix_data     = feed ? data_q : '0;
    assign o_sample       = sample_q;
    assign o_sample_valid = sample_valid_q;
    assign o_overrun      = overrun_q;
    assign o_drop         = drop_q;
    assign o_timeout      = timeout_q;
    assign fsm_state      = state;
endmodule

// File: tb/tb_mix_sequencer.sv
// Directed bench for mix_sequencer with a summing mixer model and scripted voices.
module tb_mix_sequencer;
    import mix_sequencer_pkg::*;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                i_sample_tick = 1'b0;
    logic [N_VOICES-1:0] i_voice_active = '0;
    logic                o_voice_req;
    logic [IDX_W-1:0]    o_voice_idx;
    logic [W-1:0]        i_voice_data;
    logic                i_voice_valid;
    logic                o_mix_en;
    logic [W-1:0]        o_mix_data;
    logic [W-1:0]        i_mix_out;
    logic                i_mix_rdy;
    logic [W-1:0]        o_sample;
    logic                o_sample_valid;
    logic                i_sample_ready = 1'b0;
    logic                i_clr_flags = 1'b0;
    logic                o_overrun, o_drop, o_timeout;
    state_t              fsm_state;

    logic [W-1:0]        vals [N_VOICES];
    logic [N_VOICES-1:0] resp_en = '1;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] mix_log[$];
    logic [3:0]   req_log[$];
    int   en_count = 0, frame_cnt = 0, consec_err = 0;
    logic prev_en = 1'b0;

    always #5 clk = ~clk;

    mix_sequencer dut (
        .clk(clk), .rst(rst), .i_sample_tick(i_sample_tick), .i_voice_active(i_voice_active),
        .o_voice_req(o_voice_req), .o_voice_idx(o_voice_idx), .i_voice_data(i_voice_data),
        .i_voice_valid(i_voice_valid), .o_mix_en(o_mix_en), .o_mix_data(o_mix_data),
        .i_mix_out(i_mix_out), .i_mix_rdy(i_mix_rdy), .o_sample(o_sample),
        .o_sample_valid(o_sample_valid), .i_sample_ready(i_sample_ready),
        .i_clr_flags(i_clr_flags), .o_overrun(o_overrun), .o_drop(o_drop),
        .o_timeout(o_timeout), .fsm_state(fsm_state)
    );

    // Voices answer combinationally when enabled to respond.
    assign i_voice_valid = o_voice_req & resp_en[o_voice_idx];
    assign i_voice_data  = vals[o_voice_idx];

    // Mixer model: sums ten beats, then pulses ready for one cycle with the sum.
    logic [W-1:0] acc;
    int           beats;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0; beats <= 0; i_mix_rdy <= 1'b0; i_mix_out <= '0;
        end else begin
            i_mix_rdy <= 1'b0;
            if (o_mix_en) begin
                if (beats == N_VOICES - 1) begin
                    i_mix_out <= acc + o_mix_data;
                    i_mix_rdy <= 1'b1;
                    acc       <= '0;
                    beats     <= 0;
                end else begin
                    acc   <= acc + o_mix_data;
                    beats <= beats + 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (o_mix_en) begin
                en_count++;
                mix_log.push_back(o_mix_data);
                if (prev_en) consec_err++;
            end
            if (o_voice_req) req_log.push_back(o_voice_idx);
            if (i_mix_rdy) frame_cnt++;
        end
        prev_en = o_mix_en;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_all(input logic [W-1:0] v);
        for (int k = 0; k < N_VOICES; k++) vals[k] = v;
    endtask

    task automatic tick();
        @(negedge clk) i_sample_tick = 1'b1;
        @(negedge clk) i_sample_tick = 1'b0;
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        while (!o_sample_valid && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        if (!o_sample_valid) lat = -1;
    endtask

    task automatic consume_and_clear();
        @(negedge clk) begin i_sample_ready = 1'b1; i_clr_flags = 1'b1; end
        @(negedge clk) begin i_sample_ready = 1'b0; i_clr_flags = 1'b0; end
    endtask

    task automatic check_log(input string tag, input int base);
        int n;
        n = exp_q.size();
        check({tag, "_beats"}, 32'(mix_log.size() - base), 32'(n));
        for (int i = 0; i < n; i++)
            if (base + i < mix_log.size())
                check(tag, 32'(mix_log[base + i]), 32'(exp_q[i]));
        exp_q.delete();
    endtask

    initial begin
        int lat, en_base, log_base, req_base, fr_base, n3;

        set_all(24'd0);
        repeat (3) @(negedge clk);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        check("rst_mix_en", 32'(o_mix_en), 32'd0);
        check("rst_valid", 32'(o_sample_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_sample", 32'(o_sample), 32'd0);
        check("rst_req", 32'(o_voice_req), 32'd0);
        check("rst_flags", 32'({o_overrun, o_drop, o_timeout}), 32'd0);

        // Full frame, every voice +1000.
        set_all(24'd1000);
        i_voice_active = '1;
        en_base = en_count; log_base = mix_log.size();
        tick();
        wait_valid(1, lat);
        check("t1_latency", 32'(lat), 32'd22);
        check("t1_sample", 32'(o_sample), 32'd10000);
        for (int k = 0; k < N_VOICES; k++) exp_q.push_back(24'd1000);
        check_log("t1_mix", log_base);
        check("t1_timeout", 32'(o_timeout), 32'd0);

        // Sparse mask: only voices 0 and 2 are requested.
        consume_and_clear();
        set_all(24'hABCDEF);
        vals[0] = 24'h100000; vals[2] = 24'h000010;
        i_voice_active = 10'b0000000101;
        log_base = mix_log.size(); req_base = req_log.size();
        tick();
        wait_valid(1, lat);
        check("t2_latency", 32'(lat), 32'd22);
        check("t2_sample", 32'(o_sample), 32'h100010);
        exp_q.push_back(24'h100000); exp_q.push_back(24'h0); exp_q.push_back(24'h000010);
        for (int k = 3; k < N_VOICES; k++) exp_q.push_back(24'h0);
        check_log("t2_mix", log_base);
        check("t2_req_count", 32'(req_log.size() - req_base), 32'd2);
        if (req_log.size() >= req_base + 2) begin
            check("t2_req0", 32'(req_log[req_base]), 32'd0);
            check("t2_req1", 32'(req_log[req_base + 1]), 32'd2);
        end

        // Voice 3 never answers: 15-cycle wait, zero beat, timeout flag.
        consume_and_clear();
        for (int k = 0; k < N_VOICES; k++) vals[k] = 24'(k + 1);
        i_voice_active = '1;
        resp_en = ~10'b0000001000;
        log_base = mix_log.size(); req_base = req_log.size();
        tick();
        wait_valid(1, lat);
        check("t3_latency", 32'(lat), 32'd36);
        check("t3_sample", 32'(o_sample), 32'd51);
        check("t3_timeout", 32'(o_timeout), 32'd1);
        for (int k = 0; k < N_VOICES; k++) exp_q.push_back(k == 3 ? 24'd0 : 24'(k + 1));
        check_log("t3_mix", log_base);
        n3 = 0;
        for (int i = req_base; i < req_log.size(); i++) if (req_log[i] == 4'd3) n3++;
        check("t3_req_hold", 32'(n3), 32'd15);
        resp_en = '1;

        // Second tick mid-frame is ignored and flagged.
        consume_and_clear();
        check("t4_flags_clr", 32'({o_overrun, o_drop, o_timeout}), 32'd0);
        set_all(24'd7);
        en_base = en_count;
        tick();
        repeat (8) @(negedge clk);
        i_sample_tick = 1'b1;
        @(negedge clk) i_sample_tick = 1'b0;
        wait_valid(10, lat);
        check("t4_latency", 32'(lat), 32'd22);
        check("t4_overrun", 32'(o_overrun), 32'd1);
        check("t4_sample", 32'(o_sample), 32'd70);
        repeat (30) @(negedge clk);
        check("t4_beats", 32'(en_count - en_base), 32'd10);
        check("t4_state", 32'(fsm_state), 32'(IDLE));
        @(negedge clk) i_clr_flags = 1'b1;
        @(negedge clk) i_clr_flags = 1'b0;
        check("t4_overrun_clr", 32'(o_overrun), 32'd0);

        // Two frames without ready: second overwrites the first and sets drop.
        consume_and_clear();
        set_all(24'd1);
        tick();
        wait_valid(1, lat);
        check("t5_first", 32'(o_sample), 32'd10);
        check("t5_drop0", 32'(o_drop), 32'd0);
        set_all(24'd2);
        fr_base = frame_cnt;
        tick();
        for (int c = 0; c < 60 && frame_cnt == fr_base; c++) @(negedge clk);
        check("t5_frame_seen", 32'(frame_cnt - fr_base), 32'd1);
        @(negedge clk);
        check("t5_second", 32'(o_sample), 32'd20);
        check("t5_valid", 32'(o_sample_valid), 32'd1);
        check("t5_drop1", 32'(o_drop), 32'd1);
        i_sample_ready = 1'b1;
        @(negedge clk) i_sample_ready = 1'b0;
        check("t5_consumed", 32'(o_sample_valid), 32'd0);

        // Reset after the fourth beat, then a clean frame with negative samples.
        consume_and_clear();
        set_all(24'd3);
        en_base = en_count;
        tick();
        for (int c = 0; c < 40 && (en_count - en_base) < 4; c++) @(negedge clk);
        check("t6_four_beats", 32'(en_count - en_base), 32'd4);
        rst = 1'b1;
        #1;
        check("t6_rst_state", 32'(fsm_state), 32'(IDLE));
        check("t6_rst_outs", 32'({o_mix_en, o_voice_req, o_sample_valid, o_overrun, o_drop, o_timeout}), 32'd0);
        check("t6_rst_idx", 32'(o_voice_idx), 32'd0);
        check("t6_rst_data", 32'(o_mix_data), 32'd0);
        check("t6_rst_sample", 32'(o_sample), 32'd0);
        @(negedge clk) rst = 1'b0;
        set_all(24'hFFFFFD);
        en_base = en_count; log_base = mix_log.size();
        tick();
        wait_valid(1, lat);
        check("t6_latency", 32'(lat), 32'd22);
        check("t6_sample", 32'(o_sample), 32'h00FFFFE2);
        for (int k = 0; k < N_VOICES; k++) exp_q.push_back(24'hFFFFFD);
        check_log("t6_mix", log_base);

        check("no_back_to_back_en", 32'(consec_err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
